seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed scanner for a DIGITS-wide hex display; sits directly upstream of the 7-segment decoder.
//  Latches a packed hex value and selects one digit at a time (one-hot, active-high).
//  Presents that digit's 4-bit nibble to the decoder inputs x3..x0.
//  New values take effect only at a frame boundary (no tearing); optional leading-zero blanking.
// PARAMETERS
//  DIGITS  4      number of display digits (>=1)
//  DIV     50000  clk cycles per digit slot (>=1); DIV=1 -> advance every cycle
// PORTS
//  clk         in   1          system clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  load        in   1          1-cycle strobe: capture value into pending register
//  value       in   4*DIGITS   packed hex digits; digit i = value[4*i+3:4*i], digit 0 rightmost
//  blank_en    in   1          1 = blank leading zero digits (digit 0 never blanked)
//  digit_sel   out  DIGITS     one-hot digit enable, active-high; all-zero when slot blanked
//  nibble      out  4          current digit value -> decoder x3..x0 (x3 = MSB)
//  pending     out  1          1 = loaded value waiting for frame boundary
//  frame_done  out  1          1-cycle pulse when scan wraps from digit DIGITS-1 to digit 0
// BEHAVIOUR
//  Reset (rst_n=0, async, no clock needed) clears all state:
//   - prescaler=0, idx=0, disp=0, pend_reg=0, pending=0
//   - digit_sel = 1 (digit 0 only), nibble=0, frame_done=0
//  Prescaler: cnt counts 0..DIV-1 and wraps to 0.
//   - tick asserted in the cycle where cnt==DIV-1
//  Scan index: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
//   - wrap tick = tick with idx==DIGITS-1
//  frame_done: registered; high for exactly 1 cycle, the cycle after the wrap tick edge (same cycle new idx=0 is visible).
//  Load path:
//   - load=1, not a wrap tick: pend_reg <= value, pending <= 1; repeated loads before boundary overwrite (last wins)
//   - wrap tick with pending=1 and load=0: disp <= pend_reg, pending <= 0
//   - wrap tick with load=1: disp <= value directly (overrides any pend_reg), pending <= 0
//   - wrap tick with pending=0 and load=0: disp unchanged
//  Outputs are decoded from registered idx/disp only; no input->output combinational path.
//   - nibble = disp[4*idx+3 : 4*idx]
//   - digit_sel = (1 << idx), unless slot blanked
//  Blanking: slot i (i>0) blanked when blank_en=1 and disp[4*DIGITS-1 : 4*i]==0.
//   - blanked slot: digit_sel=0; nibble still shows 0
//   - blank_en is sampled combinationally; takes effect immediately
//  Display latency: new value visible on the first slot (idx=0) of the frame after the boundary; no digit of a frame mixes old and new value.
//  Reset mid-frame: all state returns to reset values at once; scanning restarts at digit 0 with cnt=0 after rst_n rises. Any pending value is discarded.
// TESTING (DIGITS=4, DIV=4 unless noted)
//  1 Reset: rst_n=0 mid-scan, no clk edge -> digit_sel=4'b0001, nibble=0, pending=0 immediately.
//    After release: digit_sel steps 0001->0010->0100->1000->0001, every 4 clk.
//    frame_done pulses once per 16 clk.
//  2 Load 16'h1234 mid-frame -> pending=1 until boundary, then 0.
//    Next frame: nibble 4,3,2,1 with digit_sel 0001,0010,0100,1000.
//  3 Load 16'hAAAA, then 16'h0F0F before boundary -> next frame shows F,0,F,0; AAAA never displayed.
//  4 Load coincident with wrap tick (16'hBEEF) -> frame starting next cycle shows F,E,E,B.
//    pending stays 0; an older pend_reg value is discarded.
//  5 blank_en=1:
//    - disp=16'h0050 -> slot0 sel=0001 nibble 0, slot1 sel=0010 nibble 5, slots 2,3 sel=0000
//    - disp=0 -> only digit 0 lit
//    - blank_en=0 -> all four digits lit
//  6 DIV=1, DIGITS=1 -> digit_sel constant 1, frame_done high every cycle.
//    load value 4'h7 -> nibble=7 next cycle, pending never observed high.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Digit scanner for a multiplexed hex display: latches a packed value, walks a one-hot
// digit enable and presents the active digit's nibble; new values swap in only at frame wrap.
module seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_en,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [3:0]            nibble,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int IDXW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SLOTS = 1 << IDXW;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_reg_q, pend_reg_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic                tick_s;
  logic                wrap_s;
  logic [SLOTS-1:0]    lead_zero_s;
  logic                blank_s;

  // Next-state: prescaler, scan index and the pending/display handoff at the frame wrap
  always_comb begin
    tick_s       = (cnt_q == CNT_LAST);
    wrap_s       = tick_s && (idx_q == IDX_LAST);
    frame_done_d = wrap_s;
    disp_d       = disp_q;
    pend_reg_d   = pend_reg_q;
    pending_d    = pending_q;

    if (tick_s) begin
      cnt_d = {CNTW{1'b0}};
    end else begin
      cnt_d = cnt_q + CNTW'(1);
    end

    if (!tick_s) begin
      idx_d = idx_q;
    end else if (wrap_s) begin
      idx_d = {IDXW{1'b0}};
    end else begin
      idx_d = idx_q + IDXW'(1);
    end

    // A load landing on the wrap goes straight to the display; anything parked is dropped
    if (wrap_s) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d = value;
      end else if (pending_q) begin
        disp_d = pend_reg_q;
      end else begin
        disp_d = disp_q;
      end
    end else if (load) begin
      pend_reg_d = value;
      pending_d  = 1'b1;
    end else begin
      pending_d  = pending_q;
    end
  end

  // Output decode from registered state; blank_en acts without waiting for a clock
  always_comb begin
    lead_zero_s = {SLOTS{1'b0}};
    for (int i = 1; i < DIGITS; i++) begin
      lead_zero_s[i] = ((disp_q >> (4 * i)) == {(4*DIGITS){1'b0}});
    end
    blank_s = blank_en && lead_zero_s[idx_q];
    if (blank_s) begin
      digit_sel = {DIGITS{1'b0}};
    end else begin
      digit_sel = DIGITS'(1'b1) << idx_q;
    end
    nibble = 4'(disp_q >> {idx_q, 2'b00});
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {CNTW{1'b0}};
      idx_q        <= {IDXW{1'b0}};
      disp_q       <= {(4*DIGITS){1'b0}};
      pend_reg_q   <= {(4*DIGITS){1'b0}};
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_reg_q   <= pend_reg_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver: a 4-digit/DIV=4 instance and a
// 1-digit/DIV=1 instance, both checked against a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int DG = 4;
  localparam int DV = 4;
  localparam int FR = DG * DV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_a = 1'b0;
  logic [15:0] value_a = 16'h0;
  logic        blank_a = 1'b0;
  logic [3:0]  sel_a;
  logic [3:0]  nib_a;
  logic        pend_a;
  logic        fd_a;
  logic        load_b = 1'b0;
  logic [3:0]  value_b = 4'h0;
  logic        blank_b = 1'b0;
  logic [0:0]  sel_b;
  logic [3:0]  nib_b;
  logic        pend_b;
  logic        fd_b;

  int checks = 0;
  int errors = 0;

  // reference model state: t = clock edges since reset release
  int          t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_preg = 16'h0;
  bit          m_pend = 1'b0;
  bit          m_fd = 1'b0;
  logic [3:0]  mb_disp = 4'h0;
  bit          mb_fd = 1'b0;

  seg_scan_driver #(.DIGITS(DG), .DIV(DV)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .value(value_a), .blank_en(blank_a),
    .digit_sel(sel_a), .nibble(nib_a), .pending(pend_a), .frame_done(fd_a)
  );

  seg_scan_driver #(.DIGITS(1), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .value(value_b), .blank_en(blank_b),
    .digit_sel(sel_b), .nibble(nib_b), .pending(pend_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic int cur_idx();
    return (t / DV) % DG;
  endfunction

  function automatic logic [3:0] exp_sel();
    int  i;
    bit  blank;
    i = cur_idx();
    blank = blank_a && (i > 0) && ((m_disp >> (4 * i)) == 16'h0);
    return blank ? 4'b0000 : (4'b0001 << i);
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".sel"},   16'(sel_a),  16'(exp_sel()));
    check_val({tag, ".nib"},   16'(nib_a),  16'(4'(m_disp >> (4 * cur_idx()))));
    check_val({tag, ".pend"},  16'(pend_a), 16'(m_pend));
    check_val({tag, ".fd"},    16'(fd_a),   16'(m_fd));
    check_val({tag, ".b_sel"}, 16'(sel_b),  16'h1);
    check_val({tag, ".b_nib"}, 16'(nib_b),  16'(mb_disp));
    check_val({tag, ".b_pnd"}, 16'(pend_b), 16'h0);
    check_val({tag, ".b_fd"},  16'(fd_b),   16'(mb_fd));
  endtask

  // one clock: advance model with the inputs present at the edge, then compare
  task automatic step(input string tag);
    bit boundary;
    @(posedge clk);
    if (rst_n) begin
      t++;
      boundary = ((t % FR) == 0);
      if (boundary) begin
        if (load_a) m_disp = value_a;
        else if (m_pend) m_disp = m_preg;
        m_pend = 1'b0;
      end else if (load_a) begin
        m_preg = value_a;
        m_pend = 1'b1;
      end
      m_fd = boundary;
      if (load_b) mb_disp = value_b;
      mb_fd = 1'b1;
    end
    #1;
    check_all(tag);
    load_a  = 1'b0;
    load_b  = ($urandom_range(0, 2) == 0);
    value_b = 4'($urandom);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic to_wrap_edge();
    for (int k = 0; k < FR && ((t + 1) % FR) != 0; k++) step("align");
  endtask

  task automatic to_mid_frame();
    for (int k = 0; k < FR && (t % FR) != 5; k++) step("align");
  endtask

  task automatic model_reset();
    t = 0; m_disp = 16'h0; m_preg = 16'h0; m_pend = 1'b0; m_fd = 1'b0;
    mb_disp = 4'h0; mb_fd = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // free scan from reset: digit walk and frame_done cadence
    run(2 * FR, "scan");

    // load mid-frame, wait for the boundary, then watch a full frame
    to_mid_frame();
    load_a = 1'b1; value_a = 16'h1234;
    step("ld1234");
    check_val("pend_1234", 16'(pend_a), 16'h1);
    run(2 * FR, "f1234");

    // two loads before a boundary: last one wins
    to_mid_frame();
    load_a = 1'b1; value_a = 16'hAAAA; step("ldA");
    step("gap");
    load_a = 1'b1; value_a = 16'h0F0F; step("ld0F");
    run(2 * FR, "f0F0F");

    // park an older value, then load on the wrap edge itself
    to_mid_frame();
    load_a = 1'b1; value_a = 16'h1111; step("ld1111");
    to_wrap_edge();
    load_a = 1'b1; value_a = 16'hBEEF; step("ldBEEF");
    check_val("beef_nib0", 16'(nib_a), 16'hF);
    check_val("beef_pend", 16'(pend_a), 16'h0);
    run(FR, "fBEEF");

    // leading-zero blanking
    blank_a = 1'b1;
    to_wrap_edge();
    load_a = 1'b1; value_a = 16'h0050; step("ld0050");
    run(FR, "blank50");
    to_wrap_edge();
    load_a = 1'b1; value_a = 16'h0000; step("ld0000");
    run(FR, "blank0");
    blank_a = 1'b0;
    #1 check_all("unblank");
    run(FR, "noblank");

    // randomized loads and blank toggling
    for (int k = 0; k < 600; k++) begin
      load_a  = ($urandom_range(0, 6) == 0);
      value_a = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        blank_a = ~blank_a;
        #1 check_all("blank_tgl");
      end
      if ($urandom_range(0, 7) == 0) value_a = value_a & 16'h00FF;
      step("rand");
    end

    // asynchronous reset mid-frame with a pending value
    to_mid_frame();
    load_a = 1'b1; value_a = 16'h5A5A; step("ld5A5A");
    check_val("pend_pre_rst", 16'(pend_a), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_sel", 16'(sel_a), 16'h1);
    check_val("arst_nib", 16'(nib_a), 16'h0);
    check_val("arst_pend", 16'(pend_a), 16'h0);
    check_all("arst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(2 * FR, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
